// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of the data-memory bus. Converts core
// byte/half/word requests into full-word memory accesses. It handles lane
// selection, sign/zero extension and alignment faults, and performs
// read-modify-write for sub-word stores.
module load_store_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [2:0]      req_type,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_fault,
  output logic [XLEN-1:0] mem_address,
  output logic [XLEN-1:0] mem_data_in,
  input  logic [XLEN-1:0] mem_data_out,
  output logic            mem_enable,
  output logic            mem_write_enable,
  output logic [2:0]      mem_type
);

  localparam int unsigned HALF_W = 16;

  localparam logic [2:0] T_BYTE  = 3'd0;
  localparam logic [2:0] T_HALF  = 3'd1;
  localparam logic [2:0] T_WORD  = 3'd2;
  localparam logic [2:0] T_BYTEU = 3'd4;
  localparam logic [2:0] T_HALFU = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RMW_RD,
    S_WRITE,
    S_RESP
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [XLEN-1:0]     addr_q;
  logic [2:0]          type_q;
  logic [HALF_W-1:0]   wdata_q;
  logic [XLEN-1:0]     wbuf;
  logic                fault_c;
  logic                accept_c;

  // Select the addressed lane and extend it to XLEN.
  function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0] w,
                                              input logic [2:0]      t,
                                              input logic [1:0]      a);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = w[{a[1], 4'b0000} +: 16];
    case (t)
      T_BYTE:  extract = {{(XLEN-8){b[7]}}, b};
      T_BYTEU: extract = {{(XLEN-8){1'b0}}, b};
      T_HALF:  extract = {{(XLEN-16){h[15]}}, h};
      T_HALFU: extract = {{(XLEN-16){1'b0}}, h};
      default: extract = w;
    endcase
  endfunction

  // Replace the addressed byte or half of a read word with store data.
  function automatic logic [XLEN-1:0] merge(input logic [XLEN-1:0]   w,
                                            input logic [HALF_W-1:0] d,
                                            input logic [2:0]        t,
                                            input logic [1:0]        a);
    merge = w;
    if (t[0]) merge[{a[1], 4'b0000} +: 16] = d;
    else      merge[{a, 3'b000} +: 8]      = d[7:0];
  endfunction

  // Illegal type or misaligned address for the incoming request.
  always_comb begin
    fault_c = 1'b0;
    case (req_type)
      T_BYTE, T_BYTEU: fault_c = 1'b0;
      T_HALF, T_HALFU: fault_c = req_addr[0];
      T_WORD:          fault_c = (req_addr[1:0] != 2'b00);
      default:         fault_c = 1'b1;
    endcase
  end

  assign accept_c = req_valid && (state == S_IDLE);

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state logic and bus strobes decoded from the current state.
  always_comb begin
    state_next       = state;
    req_ready        = 1'b0;
    mem_enable       = 1'b0;
    mem_write_enable = 1'b0;
    mem_address      = '0;
    mem_data_in      = '0;
    mem_type         = T_WORD;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (fault_c)                 state_next = S_RESP;
          else if (!req_write)         state_next = S_LOAD;
          else if (req_type == T_WORD) state_next = S_WRITE;
          else                         state_next = S_RMW_RD;
        end
      end
      S_LOAD: begin
        mem_enable  = 1'b1;
        mem_address = {addr_q[XLEN-1:2], 2'b00};
        state_next  = S_RESP;
      end
      S_RMW_RD: begin
        mem_enable  = 1'b1;
        mem_address = {addr_q[XLEN-1:2], 2'b00};
        state_next  = S_WRITE;
      end
      S_WRITE: begin
        mem_enable       = 1'b1;
        mem_write_enable = 1'b1;
        mem_address      = {addr_q[XLEN-1:2], 2'b00};
        mem_data_in      = wbuf;
        state_next       = S_RESP;
      end
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Request capture, RMW merge buffer and registered response.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_q     <= '0;
      type_q     <= '0;
      wdata_q    <= '0;
      wbuf       <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_fault <= 1'b0;
    end else begin
      if (accept_c) begin
        addr_q  <= req_addr;
        type_q  <= req_type;
        wdata_q <= req_wdata[HALF_W-1:0];
        wbuf    <= req_wdata;
      end
      if (state == S_RMW_RD) wbuf <= merge(mem_data_out, wdata_q, type_q, addr_q[1:0]);
      resp_valid <= (state_next == S_RESP);
      resp_fault <= (state == S_IDLE) && (state_next == S_RESP);
      resp_rdata <= (state == S_LOAD) ? extract(mem_data_out, type_q, addr_q[1:0]) : '0;
    end
  end

endmodule
